// File: rtl/bsg_mux_segmented_pkg.sv
// Shared types and helpers for the buffered segmented mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bsg_mux_segmented_pkg;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Bit offset of segment `seg`'s select field inside the packed select bus.
    function automatic int sel_offset(input int seg, input int lg_els);
        return seg * lg_els;
    endfunction

endpackage

// File: rtl/bsg_mux_segmented_buffered_if.sv
// Bundle of the data/select inputs and the valid/ready in, valid/yumi out handshakes.
// Latency: n/a (wiring only).
// Backpressure: ready_o from the buffer, yumi_i from the consumer.
// Signal names are from the buffer's point of view: slave is the buffer, master drives it.
interface bsg_mux_segmented_buffered_if #(
    parameter int els_p           = 2,
    parameter int segments_p      = 4,
    parameter int segment_width_p = 4
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam int width_lp  = segments_p * segment_width_p;

    logic [els_p*width_lp-1:0]      data_i;
    logic [segments_p*lg_els_lp-1:0] sel_i;
    logic                            v_i;
    logic                            ready_o;
    logic [width_lp-1:0]             data_o;
    logic                            v_o;
    logic                            yumi_i;

    modport slave (
        input  data_i, sel_i, v_i, yumi_i,
        output ready_o, data_o, v_o
    );

    modport master (
        output data_i, sel_i, v_i, yumi_i,
        input  ready_o, data_o, v_o
    );
endinterface

// File: rtl/bsg_mux_segmented_skid.sv
// Two-entry skid buffer: valid/ready in, valid/yumi out, strict FIFO order.
// Latency: 1 cycle from accept to data_o when empty or draining the head.
// Backpressure: ready_o is registered (low only when full); no yumi_i->ready_o path.
// Ports: clk_i, reset_n_i (async active-low), data_i/v_i/ready_o in, data_o/v_o/yumi_i out.
module bsg_mux_segmented_skid
    import bsg_mux_segmented_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    skid_state_e        state_q, state_d;
    logic [width_p-1:0] head_q, head_d;
    logic [width_p-1:0] tail_q, tail_d;
    logic               ready_q, ready_d;
    logic               in_xfer, out_xfer;

    assign in_xfer  = v_i & ready_q;
    // A stray yumi while empty is ignored here and flagged by the assertion below.
    assign out_xfer = yumi_i & (state_q != EMPTY);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    head_d  = data_i;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    head_d = data_i;
                end else if (in_xfer) begin
                    state_d = TWO;
                    tail_d  = data_i;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // ready_q is low here, so only a drain can happen.
                if (out_xfer) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = (state_q != EMPTY);
    assign data_o  = head_q;

    a_no_yumi_when_empty: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> (state_q != EMPTY)
    ) else $error("yumi_i asserted while v_o is low");

endmodule

// File: rtl/bsg_mux_segmented_buffered.sv
// Per-segment word select merge feeding a two-entry skid buffer.
// Latency: 1 cycle from accepted input to data_o when the buffer is empty or draining.
// Backpressure: registered ready_o, falls only when both entries are full.
// Ports: clk_i, reset_n_i (async active-low), bus (slave: data_i, sel_i, v_i, ready_o, data_o, v_o, yumi_i).
module bsg_mux_segmented_buffered
    import bsg_mux_segmented_pkg::*;
#(
    parameter int els_p           = 2,
    parameter int segments_p      = 4,
    parameter int segment_width_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bsg_mux_segmented_buffered_if.slave   bus
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam int width_lp  = segments_p * segment_width_p;

    logic [width_lp-1:0] merged;

    for (genvar s = 0; s < segments_p; s++) begin : g_seg
        logic [lg_els_lp-1:0]       sel_s;
        logic [segment_width_p-1:0] seg_val;

        assign sel_s = bus.sel_i[sel_offset(s, lg_els_lp) +: lg_els_lp];

        // A select with no matching word (>= els_p) leaves the segment zero.
        always_comb begin
            seg_val = '0;
            for (int k = 0; k < els_p; k++) begin
                if (sel_s == lg_els_lp'(k)) begin
                    seg_val = bus.data_i[k*width_lp + s*segment_width_p +: segment_width_p];
                end
            end
        end

        assign merged[s*segment_width_p +: segment_width_p] = seg_val;
    end

    bsg_mux_segmented_skid #(
        .width_p (width_lp)
    ) u_skid (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (merged),
        .v_i       (bus.v_i),
        .ready_o   (bus.ready_o),
        .data_o    (bus.data_o),
        .v_o       (bus.v_o),
        .yumi_i    (bus.yumi_i)
    );

endmodule

// File: tb/tb_bsg_mux_segmented_buffered.sv
// Directed bench for the buffered segmented mux (default config plus a 3-word config).
// Latency: n/a.
// Backpressure: exercised through yumi_i patterns.
module tb_bsg_mux_segmented_buffered;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bsg_mux_segmented_buffered_if #(.els_p(2), .segments_p(4), .segment_width_p(4)) a_if ();
    bsg_mux_segmented_buffered_if #(.els_p(3), .segments_p(4), .segment_width_p(4)) b_if ();

    bsg_mux_segmented_buffered #(.els_p(2), .segments_p(4), .segment_width_p(4)) dut_a (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (a_if.slave)
    );

    bsg_mux_segmented_buffered #(.els_p(3), .segments_p(4), .segment_width_p(4)) dut_b (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (b_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive word0 of the default DUT with all segments selecting word 0.
    task automatic push_a(input logic [15:0] w, input logic v, input logic yumi);
        a_if.data_i = {16'h0000, w};
        a_if.sel_i  = 4'b0000;
        a_if.v_i    = v;
        a_if.yumi_i = yumi;
    endtask

    function automatic logic [15:0] stream_word(input int i);
        logic [15:0] w;
        w = 16'(i) * 16'h0101;
        return w ^ 16'h5A5A;
    endfunction

    initial begin
        rst_n       = 1'b0;
        a_if.data_i = '0;
        a_if.sel_i  = '0;
        a_if.v_i    = 1'b0;
        a_if.yumi_i = 1'b0;
        b_if.data_i = {16'h0000, 16'h0000, 16'h1234};
        b_if.sel_i  = 8'h30;   // seg2 -> 3 (out of range), others -> word 0
        b_if.v_i    = 1'b0;
        b_if.yumi_i = 1'b0;

        #12;
        check("reset_v_o",     32'(a_if.v_o),     32'h0);
        check("reset_ready_o", 32'(a_if.ready_o), 32'h1);
        check("reset_data_o",  32'(a_if.data_o),  32'h0);
        check("reset_b_v_o",   32'(b_if.v_o),     32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Merge: alternate words per segment; out-of-range select on DUT B.
        a_if.data_i = {16'hBBBB, 16'hAAAA};
        a_if.sel_i  = 4'b0101;
        a_if.v_i    = 1'b1;
        b_if.v_i    = 1'b1;
        step();
        a_if.v_i = 1'b0;
        b_if.v_i = 1'b0;
        check("merge_data",   32'(a_if.data_o),  32'hABAB);
        check("merge_v",      32'(a_if.v_o),     32'h1);
        check("merge_ready",  32'(a_if.ready_o), 32'h1);
        check("oor_data",     32'(b_if.data_o),  32'h1034);
        check("oor_v",        32'(b_if.v_o),     32'h1);

        // Second merge pattern, taken together with draining ABAB.
        a_if.data_i = {16'hFEDC, 16'h0123};
        a_if.sel_i  = 4'b0011;
        a_if.v_i    = 1'b1;
        a_if.yumi_i = 1'b1;
        step();
        check("merge2_data", 32'(a_if.data_o), 32'h01DC);
        a_if.v_i = 1'b0;
        step();
        a_if.yumi_i = 1'b0;
        check("drain_v", 32'(a_if.v_o), 32'h0);

        // Backpressure: three offers with no consumer.
        push_a(16'h0001, 1'b1, 1'b0);
        step();
        check("bp_ready_after1", 32'(a_if.ready_o), 32'h1);
        push_a(16'h0002, 1'b1, 1'b0);
        step();
        check("bp_ready_after2", 32'(a_if.ready_o), 32'h0);
        check("bp_head1",        32'(a_if.data_o),  32'h0001);
        push_a(16'h0003, 1'b1, 1'b0);
        step();
        check("bp_held_ready",   32'(a_if.ready_o), 32'h0);
        check("bp_held_head",    32'(a_if.data_o),  32'h0001);
        push_a(16'h0003, 1'b1, 1'b1);
        step();
        check("bp_head2",        32'(a_if.data_o),  32'h0002);
        check("bp_ready_return", 32'(a_if.ready_o), 32'h1);
        step();
        check("bp_head3",        32'(a_if.data_o),  32'h0003);
        check("bp_v3",           32'(a_if.v_o),     32'h1);
        push_a(16'h0000, 1'b0, 1'b1);
        step();
        check("bp_empty", 32'(a_if.v_o), 32'h0);

        // Simultaneous in/out while holding one word.
        push_a(16'h00AA, 1'b1, 1'b0);
        step();
        check("sim_first", 32'(a_if.data_o), 32'h00AA);
        push_a(16'h00BB, 1'b1, 1'b1);
        step();
        check("sim_new_head", 32'(a_if.data_o),  32'h00BB);
        check("sim_v",        32'(a_if.v_o),     32'h1);
        check("sim_ready",    32'(a_if.ready_o), 32'h1);
        push_a(16'h0000, 1'b0, 1'b1);
        step();
        check("sim_empty", 32'(a_if.v_o), 32'h0);

        // Streaming: 100 words, one per cycle.
        push_a(stream_word(0), 1'b1, 1'b0);
        step();
        check("stream_first", 32'(a_if.data_o), 32'(stream_word(0)));
        for (int i = 1; i < 100; i++) begin
            push_a(stream_word(i), 1'b1, 1'b1);
            step();
            check("stream_data",  32'(a_if.data_o),  32'(stream_word(i)));
            check("stream_ready", 32'(a_if.ready_o), 32'h1);
        end
        push_a(16'h0000, 1'b0, 1'b1);
        step();
        check("stream_empty", 32'(a_if.v_o), 32'h0);

        // Reset while full, mid-cycle.
        push_a(16'h0C0C, 1'b1, 1'b0);
        step();
        push_a(16'h0D0D, 1'b1, 1'b0);
        step();
        push_a(16'h0000, 1'b0, 1'b0);
        check("full_ready", 32'(a_if.ready_o), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_v_o",     32'(a_if.v_o),     32'h0);
        check("arst_data_o",  32'(a_if.data_o),  32'h0);
        check("arst_ready_o", 32'(a_if.ready_o), 32'h1);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_v",     32'(a_if.v_o),     32'h0);
        check("post_rst_ready", 32'(a_if.ready_o), 32'h1);
        push_a(16'h0E0E, 1'b1, 1'b0);
        step();
        push_a(16'h0000, 1'b0, 1'b0);
        check("post_rst_data", 32'(a_if.data_o), 32'h0E0E);
        check("post_rst_v1",   32'(a_if.v_o),    32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
